axi_lite_arbiter: RTL and testbench

- Shares one AXI4-Lite slave between NUM_MASTERS AXI4-Lite masters in the interconnect.
- Arbitrates round-robin and grants one complete transaction at a time (read or write), from address handshake through response handshake.
- Forwards the granted master's channels to the slave and routes responses back to that master only.
- Sits between the master-side and slave-side axi_lite_if instances in the interconnect top.

---
 rtl/axi_lite_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter
//   Shares one AXI4-Lite slave between NUM_MASTERS AXI4-Lite masters.
//   Round-robin arbitration. One complete transaction (read or write) is
//   granted at a time, from address handshake through response handshake.
//   The granted master's channels are forwarded to the slave, and responses
//   are routed back to that master only.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When ARB_TIMEOUT_EN is defined, a response watchdog is built in. If the
//   slave does not answer within TIMEOUT_CYCLES, the arbiter returns SLVERR
//   to the granted master. When it is undefined, the arbiter waits
//   indefinitely for the slave's response.
//
// Ports
//   aclk, areset_n          clock, asynchronous active-low reset
//   m_aw*/m_w*/m_b*         per-master write channels (packed, master i at slice i)
//   m_ar*/m_r*              per-master read channels (m_rdata/m_rresp/m_bresp shared)
//   s_aw*/s_w*/s_b*         slave write channels
//   s_ar*/s_r*              slave read channels
//   grant_id                index of the current or last-granted master
//   busy                    high whenever a transaction is in progress
module axi_lite_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                aclk,
    input  logic                                areset_n,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_awaddr,
    input  logic [NUM_MASTERS-1:0]              m_awvalid,
    output logic [NUM_MASTERS-1:0]              m_awready,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_wstrb,
    input  logic [NUM_MASTERS-1:0]              m_wvalid,
    output logic [NUM_MASTERS-1:0]              m_wready,
    output logic [1:0]                          m_bresp,
    output logic [NUM_MASTERS-1:0]              m_bvalid,
    input  logic [NUM_MASTERS-1:0]              m_bready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_araddr,
    input  logic [NUM_MASTERS-1:0]              m_arvalid,
    output logic [NUM_MASTERS-1:0]              m_arready,
    output logic [DATA_WIDTH-1:0]               m_rdata,
    output logic [1:0]                          m_rresp,
    output logic [NUM_MASTERS-1:0]              m_rvalid,
    input  logic [NUM_MASTERS-1:0]              m_rready,
    output logic [ADDR_WIDTH-1:0]               s_awaddr,
    output logic                                s_awvalid,
    input  logic                                s_awready,
    output logic [DATA_WIDTH-1:0]               s_wdata,
    output logic [DATA_WIDTH/8-1:0]             s_wstrb,
    output logic                                s_wvalid,
    input  logic                                s_wready,
    input  logic [1:0]                          s_bresp,
    input  logic                                s_bvalid,
    output logic                                s_bready,
    output logic [ADDR_WIDTH-1:0]               s_araddr,
    output logic                                s_arvalid,
    input  logic                                s_arready,
    input  logic [DATA_WIDTH-1:0]               s_rdata,
    input  logic [1:0]                          s_rresp,
    input  logic                                s_rvalid,
    output logic                                s_rready,
    output logic [$clog2(NUM_MASTERS)-1:0]      grant_id,
    output logic                                busy
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA} state_t;

    state_t                 state;
    logic [IW-1:0]          grant;
    logic [IW-1:0]          last;
    logic                   aw_done;
    logic                   w_done;
    logic [NUM_MASTERS-1:0] req;
    logic [IW-1:0]          sel;
    logic                   sel_vld;
    logic [IW-1:0]          cand;
    int                     idx;
    logic                   aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                   tmo;

    assign req = m_awvalid | m_arvalid;

    // Scan from the farthest candidate back toward last+1 so that the
    // nearest requester after last overwrites any later one.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            cand = IW'(idx);
            if (req[cand]) begin
                sel     = cand;
                sel_vld = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;

    // Counter is zero on the first waiting cycle and saturates at the limit;
    // reaching the limit hands the response over to the arbiter itself.
    assign tmo = (tmo_cnt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            tmo_cnt <= '0;
        end else if (state == WR_RESP || state == RD_DATA) begin
            if (!tmo) tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    // Channel routing. Everything is gated by state so that idle and
    // non-granted masters see all ready/valid outputs low.
    always_comb begin
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_arready = '0;
        m_rvalid  = '0;
        m_bresp   = s_bresp;
        m_rdata   = s_rdata;
        m_rresp   = s_rresp;
        s_awaddr  = m_awaddr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
        s_wdata   = m_wdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        s_wstrb   = m_wstrb[int'(grant)*SW +: SW];
        s_araddr  = m_araddr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        case (state)
            WR_ADDR: begin
                s_awvalid        = m_awvalid[grant] & ~aw_done;
                s_wvalid         = m_wvalid[grant] & ~w_done;
                m_awready[grant] = s_awready & ~aw_done;
                m_wready[grant]  = s_wready & ~w_done;
            end
            WR_RESP: begin
                if (tmo) begin
                    m_bvalid[grant] = 1'b1;
                    m_bresp         = 2'b10;
                end else begin
                    m_bvalid[grant] = s_bvalid;
                    s_bready        = m_bready[grant];
                end
            end
            RD_ADDR: begin
                s_arvalid        = m_arvalid[grant];
                m_arready[grant] = s_arready;
            end
            RD_DATA: begin
                if (tmo) begin
                    m_rvalid[grant] = 1'b1;
                    m_rresp         = 2'b10;
                    m_rdata         = '0;
                end else begin
                    m_rvalid[grant] = s_rvalid;
                    s_rready        = m_rready[grant];
                end
            end
            default: ;
        endcase
    end

    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid & s_wready;
    // Response handshakes are taken on the master side so the watchdog's own
    // SLVERR response completes the transaction the same way a real one does.
    assign b_hs  = m_bvalid[grant] & m_bready[grant];
    assign ar_hs = s_arvalid & s_arready;
    assign r_hs  = m_rvalid[grant] & m_rready[grant];

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state   <= IDLE;
            grant   <= '0;
            last    <= IW'(NUM_MASTERS - 1);
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        grant   <= sel;
                        last    <= sel;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        // A master offering both a write and a read gets the
                        // write now; its read is picked up on a later grant.
                        state   <= m_awvalid[sel] ? WR_ADDR : RD_ADDR;
                    end
                end
                WR_ADDR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done | aw_hs) && (w_done | w_hs)) state <= WR_RESP;
                end
                WR_RESP: if (b_hs)  state <= IDLE;
                RD_ADDR: if (ar_hs) state <= RD_DATA;
                RD_DATA: if (r_hs)  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign grant_id = grant;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed testbench for axi_lite_arbiter with two masters. The bench plays
// both the masters and the slave; inputs change on the falling clock edge and
// outputs are sampled 1 time unit later.
module tb_axi_lite_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            aclk = 1'b0;
    logic            areset_n;
    logic [N*AW-1:0] m_awaddr;
    logic [N-1:0]    m_awvalid, m_awready;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic [N-1:0]    m_wvalid, m_wready;
    logic [1:0]      m_bresp;
    logic [N-1:0]    m_bvalid, m_bready;
    logic [N*AW-1:0] m_araddr;
    logic [N-1:0]    m_arvalid, m_arready;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic [N-1:0]    m_rvalid, m_rready;
    logic [AW-1:0]   s_awaddr;
    logic            s_awvalid, s_awready;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_wstrb;
    logic            s_wvalid, s_wready;
    logic [1:0]      s_bresp;
    logic            s_bvalid, s_bready;
    logic [AW-1:0]   s_araddr;
    logic            s_arvalid, s_arready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rvalid, s_rready;
    logic [0:0]      grant_id;
    logic            busy;

    int tests = 0;
    int fails = 0;

    always #5 aclk = ~aclk;

    axi_lite_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(256)
    ) dut (
        .aclk(aclk), .areset_n(areset_n),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant_id(grant_id), .busy(busy)
    );

    task automatic clear_inputs();
        m_awaddr = '0; m_awvalid = '0; m_wdata = '0; m_wstrb = '0; m_wvalid = '0;
        m_bready = '0; m_araddr = '0; m_arvalid = '0; m_rready = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bresp = 2'b00; s_bvalid = 1'b0;
        s_arready = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        areset_n = 1'b0;
        repeat (2) @(negedge aclk);
        areset_n = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_reset();
        clear_inputs();
        areset_n = 1'b0;
        @(negedge aclk);
        // requests during reset must be ignored
        m_awvalid = 2'b01; m_wvalid = 2'b01; m_arvalid = 2'b10;
        s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1; s_bvalid = 1'b1; s_rvalid = 1'b1;
        @(negedge aclk); #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (grant_id !== 1'b0) begin fails++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        tests++; if ({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready} !== 5'b0) begin
            fails++; $display("FAIL reset_slave_ctl: got %b expected 00000", {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}); end
        tests++; if ({m_awready, m_wready, m_bvalid, m_arready, m_rvalid} !== 10'b0) begin
            fails++; $display("FAIL reset_master_ctl: got %b expected 0", {m_awready, m_wready, m_bvalid, m_arready, m_rvalid}); end
        clear_inputs();
        areset_n = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_single_write();
        do_reset();
        m_awvalid[0] = 1'b1; m_awaddr[0 +: AW] = 32'h10;
        m_wvalid[0] = 1'b1; m_wdata[0 +: DW] = 32'hA5A5A5A5; m_wstrb[0 +: SW] = 4'hF;
        m_bready[0] = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        #1;
        tests++; if (s_awvalid !== 1'b0) begin fails++; $display("FAIL wr_arb_latency: s_awvalid got %b expected 0", s_awvalid); end
        @(negedge aclk); #1;
        tests++; if (grant_id !== 1'b0) begin fails++; $display("FAIL wr_grant: got %0d expected 0", grant_id); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_busy: got %b expected 1", busy); end
        tests++; if ({s_awvalid, s_wvalid} !== 2'b11) begin fails++; $display("FAIL wr_slave_valid: got %b expected 11", {s_awvalid, s_wvalid}); end
        tests++; if (s_awaddr !== 32'h10) begin fails++; $display("FAIL wr_awaddr: got %h expected 00000010", s_awaddr); end
        tests++; if (s_wdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL wr_wdata: got %h expected a5a5a5a5", s_wdata); end
        tests++; if (s_wstrb !== 4'hF) begin fails++; $display("FAIL wr_wstrb: got %h expected f", s_wstrb); end
        tests++; if ({m_awready, m_wready} !== 4'b0101) begin fails++; $display("FAIL wr_m_ready: got %b expected 0101", {m_awready, m_wready}); end
        @(negedge aclk);
        m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0;
        s_bvalid = 1'b1; s_bresp = 2'b00;
        #1;
        tests++; if (m_bvalid !== 2'b01) begin fails++; $display("FAIL wr_bvalid: got %b expected 01", m_bvalid); end
        tests++; if (m_bresp !== 2'b00) begin fails++; $display("FAIL wr_bresp: got %b expected 00", m_bresp); end
        tests++; if (s_bready !== 1'b1) begin fails++; $display("FAIL wr_s_bready: got %b expected 1", s_bready); end
        tests++; if (s_awvalid !== 1'b0) begin fails++; $display("FAIL wr_aw_after_done: got %b expected 0", s_awvalid); end
        @(negedge aclk);
        s_bvalid = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wr_idle_after: busy got %b expected 0", busy); end
        tests++; if (m_bvalid !== 2'b00) begin fails++; $display("FAIL wr_bvalid_after: got %b expected 00", m_bvalid); end
        clear_inputs();
    endtask

    task automatic test_two_reads();
        do_reset();
        m_arvalid = 2'b11;
        m_araddr[0 +: AW] = 32'h100; m_araddr[AW +: AW] = 32'h200;
        m_rready = 2'b11; s_arready = 1'b1;
        @(negedge aclk); #1;
        tests++; if (grant_id !== 1'b0) begin fails++; $display("FAIL rd_first_grant: got %0d expected 0", grant_id); end
        tests++; if (s_araddr !== 32'h100) begin fails++; $display("FAIL rd_first_addr: got %h expected 00000100", s_araddr); end
        tests++; if (m_arready !== 2'b01) begin fails++; $display("FAIL rd_first_arready: got %b expected 01", m_arready); end
        @(negedge aclk);
        m_arvalid[0] = 1'b0;
        s_rvalid = 1'b1; s_rdata = 32'h11110000; s_rresp = 2'b00;
        #1;
        tests++; if (m_rvalid !== 2'b01) begin fails++; $display("FAIL rd_first_rvalid: got %b expected 01", m_rvalid); end
        tests++; if (m_rdata !== 32'h11110000) begin fails++; $display("FAIL rd_first_rdata: got %h expected 11110000", m_rdata); end
        @(negedge aclk);
        s_rvalid = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rd_gap_idle: busy got %b expected 0", busy); end
        @(negedge aclk); #1;
        tests++; if (grant_id !== 1'b1) begin fails++; $display("FAIL rd_second_grant: got %0d expected 1", grant_id); end
        tests++; if (s_araddr !== 32'h200) begin fails++; $display("FAIL rd_second_addr: got %h expected 00000200", s_araddr); end
        tests++; if (m_arready !== 2'b10) begin fails++; $display("FAIL rd_second_arready: got %b expected 10", m_arready); end
        @(negedge aclk);
        m_arvalid[1] = 1'b0;
        s_rvalid = 1'b1; s_rdata = 32'h22220000;
        #1;
        tests++; if (m_rvalid !== 2'b10) begin fails++; $display("FAIL rd_second_rvalid: got %b expected 10", m_rvalid); end
        tests++; if (m_rdata !== 32'h22220000) begin fails++; $display("FAIL rd_second_rdata: got %h expected 22220000", m_rdata); end
        @(negedge aclk);
        s_rvalid = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rd_end_idle: busy got %b expected 0", busy); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        int         aw_cnt[2];
        logic       pend[2];
        int         order_n;
        int         b_n;
        int         last_g;
        int         g;
        logic [31:0] exp_w;
        logic [1:0]  exp_b;
        do_reset();
        aw_cnt[0] = 0; aw_cnt[1] = 0; pend[0] = 1'b0; pend[1] = 1'b0;
        order_n = 0; b_n = 0; last_g = 0;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; s_bresp = 2'b00;
        m_bready = 2'b11;
        for (int i = 0; i < N; i++) begin
            m_awvalid[i] = 1'b1; m_wvalid[i] = 1'b1;
            m_awaddr[i*AW +: AW] = 32'h1000 + 32'(i * 16);
            m_wdata[i*DW +: DW] = 32'hD0000000 | 32'(i << 8);
            m_wstrb[i*SW +: SW] = 4'hF;
        end
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge aclk);
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    pend[i] = 1'b0;
                    aw_cnt[i]++;
                    if (aw_cnt[i] == 4) begin
                        m_awvalid[i] = 1'b0; m_wvalid[i] = 1'b0;
                    end else begin
                        m_wdata[i*DW +: DW] = 32'hD0000000 | 32'(i << 8) | 32'(aw_cnt[i]);
                    end
                end
            end
            #1;
            if (s_awvalid && s_awready) begin
                g = int'(grant_id);
                tests++; if (g != (order_n % 2)) begin fails++; $display("FAIL b2b_order[%0d]: got %0d expected %0d", order_n, g, order_n % 2); end
                exp_w = 32'hD0000000 | 32'(g << 8) | 32'(aw_cnt[g]);
                tests++; if (s_wdata !== exp_w) begin fails++; $display("FAIL b2b_wdata[%0d]: got %h expected %h", order_n, s_wdata, exp_w); end
                pend[g] = 1'b1;
                last_g = g;
                order_n++;
            end
            if (m_bvalid != 2'b00) begin
                exp_b = 2'(1 << last_g);
                tests++; if (m_bvalid !== exp_b) begin fails++; $display("FAIL b2b_broute[%0d]: got %b expected %b", b_n, m_bvalid, exp_b); end
                b_n++;
            end
        end
        tests++; if (order_n != 8) begin fails++; $display("FAIL b2b_aw_total: got %0d expected 8", order_n); end
        tests++; if (b_n != 8) begin fails++; $display("FAIL b2b_b_total: got %0d expected 8", b_n); end
        tests++; if (aw_cnt[0] != 4 || aw_cnt[1] != 4) begin fails++; $display("FAIL b2b_per_master: got %0d/%0d expected 4/4", aw_cnt[0], aw_cnt[1]); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_end: busy got %b expected 0", busy); end
        clear_inputs();
        @(negedge aclk);
    endtask

    task automatic test_aw_ar_together();
        m_awvalid[1] = 1'b1; m_awaddr[AW +: AW] = 32'h40;
        m_wvalid[1] = 1'b1; m_wdata[DW +: DW] = 32'h12345678; m_wstrb[SW +: SW] = 4'h3;
        m_arvalid[1] = 1'b1; m_araddr[AW +: AW] = 32'h44;
        m_bready[1] = 1'b1; m_rready[1] = 1'b1;
        s_wready = 1'b1; s_awready = 1'b0; s_arready = 1'b1;
        @(negedge aclk); #1;
        tests++; if (grant_id !== 1'b1) begin fails++; $display("FAIL awar_grant: got %0d expected 1", grant_id); end
        tests++; if ({s_awvalid, s_wvalid, s_arvalid} !== 3'b110) begin fails++; $display("FAIL awar_write_first: got %b expected 110", {s_awvalid, s_wvalid, s_arvalid}); end
        tests++; if ({m_awready, m_wready} !== 4'b0010) begin fails++; $display("FAIL awar_w_only_ready: got %b expected 0010", {m_awready, m_wready}); end
        tests++; if (s_wstrb !== 4'h3) begin fails++; $display("FAIL awar_wstrb: got %h expected 3", s_wstrb); end
        @(negedge aclk);
        m_wvalid[1] = 1'b0;
        #1;
        tests++; if ({busy, s_wvalid, s_awvalid} !== 3'b101) begin fails++; $display("FAIL awar_w_done: got %b expected 101", {busy, s_wvalid, s_awvalid}); end
        @(negedge aclk); #1;
        tests++; if (s_awvalid !== 1'b1) begin fails++; $display("FAIL awar_aw_wait: got %b expected 1", s_awvalid); end
        @(negedge aclk);
        s_awready = 1'b1;
        #1;
        tests++; if (m_awready !== 2'b10) begin fails++; $display("FAIL awar_awready: got %b expected 10", m_awready); end
        @(negedge aclk);
        m_awvalid[1] = 1'b0; s_bvalid = 1'b1;
        #1;
        tests++; if (m_bvalid !== 2'b10) begin fails++; $display("FAIL awar_bvalid: got %b expected 10", m_bvalid); end
        tests++; if (s_arvalid !== 1'b0) begin fails++; $display("FAIL awar_no_ar_yet: got %b expected 0", s_arvalid); end
        @(negedge aclk);
        s_bvalid = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL awar_gap: busy got %b expected 0", busy); end
        @(negedge aclk); #1;
        tests++; if ({grant_id, s_arvalid} !== 2'b11) begin fails++; $display("FAIL awar_rd_grant: got %b expected 11", {grant_id, s_arvalid}); end
        tests++; if (s_araddr !== 32'h44) begin fails++; $display("FAIL awar_araddr: got %h expected 00000044", s_araddr); end
        @(negedge aclk);
        m_arvalid[1] = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hCAFEF00D;
        #1;
        tests++; if (m_rvalid !== 2'b10) begin fails++; $display("FAIL awar_rvalid: got %b expected 10", m_rvalid); end
        tests++; if (m_rdata !== 32'hCAFEF00D) begin fails++; $display("FAIL awar_rdata: got %h expected cafef00d", m_rdata); end
        @(negedge aclk);
        s_rvalid = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL awar_end: busy got %b expected 0", busy); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        do_reset();
        m_awvalid[0] = 1'b1; m_awaddr[0 +: AW] = 32'h20;
        m_wvalid[0] = 1'b1; m_wdata[0 +: DW] = 32'h5A5A0000; m_wstrb[0 +: SW] = 4'hF;
        m_bready[0] = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0;
`ifdef ARB_TIMEOUT_EN
        #1;
        for (int i = 0; i < 256; i++) begin
            if (m_bvalid != 2'b00 || busy !== 1'b1) early++;
            @(negedge aclk); #1;
        end
        tests++; if (early != 0) begin fails++; $display("FAIL tmo_early: got %0d bad cycles expected 0", early); end
        tests++; if (m_bvalid !== 2'b01) begin fails++; $display("FAIL tmo_bvalid: got %b expected 01", m_bvalid); end
        tests++; if (m_bresp !== 2'b10) begin fails++; $display("FAIL tmo_bresp: got %b expected 10", m_bresp); end
        tests++; if (s_bready !== 1'b0) begin fails++; $display("FAIL tmo_s_bready: got %b expected 0", s_bready); end
        @(negedge aclk); #1;
        tests++; if ({busy, s_bready, m_bvalid} !== 4'b0) begin fails++; $display("FAIL tmo_end: got %b expected 0000", {busy, s_bready, m_bvalid}); end
`else
        #1;
        for (int i = 0; i < 300; i++) begin
            if (m_bvalid != 2'b00 || busy !== 1'b1) early++;
            @(negedge aclk); #1;
        end
        tests++; if (early != 0) begin fails++; $display("FAIL notmo_wait: got %0d bad cycles expected 0", early); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL notmo_busy: got %b expected 1", busy); end
`endif
        do_reset();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_arvalid[0] = 1'b1; m_araddr[0 +: AW] = 32'h300;
        m_rready = 2'b11; s_arready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        m_arvalid[0] = 1'b0;
        s_rvalid = 1'b1; s_rdata = 32'hDEAD0000;
        #1;
        tests++; if (m_rvalid !== 2'b01) begin fails++; $display("FAIL mid_rvalid_before: got %b expected 01", m_rvalid); end
        areset_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b expected 0", busy); end
        tests++; if ({m_rvalid, s_rready, s_arvalid, s_awvalid, s_wvalid} !== 6'b0) begin
            fails++; $display("FAIL mid_valids: got %b expected 000000", {m_rvalid, s_rready, s_arvalid, s_awvalid, s_wvalid}); end
        @(negedge aclk);
        areset_n = 1'b1;
        s_rvalid = 1'b0;
        m_arvalid = 2'b11; m_araddr[AW +: AW] = 32'h304;
        @(negedge aclk); #1;
        tests++; if ({busy, grant_id} !== 2'b10) begin fails++; $display("FAIL mid_regrant: got %b expected 10", {busy, grant_id}); end
        tests++; if (m_arready !== 2'b01) begin fails++; $display("FAIL mid_regrant_ready: got %b expected 01", m_arready); end
        do_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        areset_n = 1'b0;
        test_reset();
        test_single_write();
        test_two_reads();
        test_back_to_back();
        test_aw_ar_together();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
